// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flag register, condition evaluation and write-strobe gating
//
// Execute-stage consumer of the ALU flags. Evaluates each instruction's
// condition field against the architectural flag register and registers the
// gated PC-select, register-write and memory-write strobes into the
// execute/memory boundary (one cycle latency).
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   valid_i       execute-stage instruction valid
//   stall_i       hold all state and outputs
//   flush_i       kill the current execute-stage instruction
//   cond_i        instruction condition field
//   alu_flags_i   ALU flags [3]=N [2]=Z [1]=C [0]=V
//   flag_w_i      [1] updates N,Z; [0] updates C,V
//   pcs_i         instruction writes PC
//   reg_w_i       instruction writes register file
//   mem_w_i       instruction writes memory
//   no_write_i    compare-type instruction, suppress register write
//   valid_o       registered instruction valid
//   pc_src_o      registered gated PC select
//   reg_write_o   registered gated register write
//   mem_write_o   registered gated memory write
//   undef_o       registered: condition 4'b1111 seen on a valid instruction
//   flags_o       current flag register, same bit order as alu_flags_i
//   exec_cnt_o    executed-instruction counter (COND_PERF_CNT_EN only)
//   squash_cnt_o  squashed-instruction counter (COND_PERF_CNT_EN only)
//
// Optional feature macro: COND_PERF_CNT_EN adds saturating CNT_W-bit
// executed/squashed instruction counters and their output ports.

module cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [3:0]       cond_i,
  input  logic [3:0]       alu_flags_i,
  input  logic [1:0]       flag_w_i,
  input  logic             pcs_i,
  input  logic             reg_w_i,
  input  logic             mem_w_i,
  input  logic             no_write_i,
  output logic             valid_o,
  output logic             pc_src_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             undef_o,
  output logic [3:0]       flags_o
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] exec_cnt_o,
  output logic [CNT_W-1:0] squash_cnt_o
`endif
);

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("cond_unit: CNT_W must be at least 1");
  end

  // Architectural flag register and registered execute/memory outputs.
  logic [3:0] flags_q, flags_d;
  logic       valid_q, valid_d;
  logic       pc_src_q, pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;
  logic       undef_q, undef_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;
  logic acc;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Condition is judged on the committed flag register only; the ALU flags of
  // the same instruction never influence its own condition.
  always_comb begin
    cond_ex = 1'b0;
    case (cond_i)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign acc = valid_i & ~stall_i & ~flush_i;

  // Stall takes priority over flush: a flush raised during a stall is dropped
  // and has to be presented again once the stall releases.
  always_comb begin
    flags_d     = flags_q;
    valid_d     = valid_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    undef_d     = undef_q;

    if (!stall_i) begin
      if (flush_i) begin
        valid_d     = 1'b0;
        pc_src_d    = 1'b0;
        reg_write_d = 1'b0;
        mem_write_d = 1'b0;
        undef_d     = 1'b0;
      end else begin
        valid_d     = valid_i;
        pc_src_d    = valid_i & pcs_i & cond_ex;
        reg_write_d = valid_i & reg_w_i & ~no_write_i & cond_ex;
        mem_write_d = valid_i & mem_w_i & cond_ex;
        undef_d     = valid_i & (cond_i == 4'b1111);
      end
    end

    // Each flag pair loads independently; unselected pairs keep their value.
    if (acc && cond_ex) begin
      if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q     <= 4'b0000;
      valid_q     <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      undef_q     <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      valid_q     <= valid_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      undef_q     <= undef_d;
    end
  end

  assign flags_o     = flags_q;
  assign valid_o     = valid_q;
  assign pc_src_o    = pc_src_q;
  assign reg_write_o = reg_write_q;
  assign mem_write_o = mem_write_q;
  assign undef_o     = undef_q;

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  // Counters only move on an accepted instruction and stick at all-ones.
  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (acc) begin
      if (cond_ex) begin
        if (exec_cnt_q != {CNT_W{1'b1}}) exec_cnt_d = exec_cnt_q + 1'b1;
      end else begin
        if (squash_cnt_q != {CNT_W{1'b1}}) squash_cnt_d = squash_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign exec_cnt_o   = exec_cnt_q;
  assign squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb/tb_cond_unit.sv - self-checking bench for cond_unit against a behavioural flag model

module tb_cond_unit;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       valid_i, stall_i, flush_i;
  logic [3:0] cond_i, alu_flags_i;
  logic [1:0] flag_w_i;
  logic       pcs_i, reg_w_i, mem_w_i, no_write_i;
  logic       valid_o, pc_src_o, reg_write_o, mem_write_o, undef_o;
  logic [3:0] flags_o;
`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_cnt_o, squash_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .cond_i      (cond_i),
    .alu_flags_i (alu_flags_i),
    .flag_w_i    (flag_w_i),
    .pcs_i       (pcs_i),
    .reg_w_i     (reg_w_i),
    .mem_w_i     (mem_w_i),
    .no_write_i  (no_write_i),
    .valid_o     (valid_o),
    .pc_src_o    (pc_src_o),
    .reg_write_o (reg_write_o),
    .mem_write_o (mem_write_o),
    .undef_o     (undef_o),
    .flags_o     (flags_o)
`ifdef COND_PERF_CNT_EN
    ,
    .exec_cnt_o  (exec_cnt_o),
    .squash_cnt_o(squash_cnt_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: flags as individual N/Z/C/V plus expected registered outputs.
  bit m_n, m_z, m_c, m_v;
  bit m_valid, m_pc, m_reg, m_mem, m_undef;
  int m_exec, m_squash;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Conditions come in complementary pairs: even code is the base test,
  // odd code its inverse; 1111 never passes.
  function automatic bit passes(input logic [3:0] cond);
    bit base;
    if (cond == 4'hF) return 1'b0;
    case (int'(cond) / 2)
      0: base = m_z;
      1: base = m_c;
      2: base = m_n;
      3: base = m_v;
      4: base = m_c && !m_z;
      5: base = (m_n == m_v);
      6: base = !m_z && (m_n == m_v);
      default: base = 1'b1;
    endcase
    return (cond % 2 == 1) ? !base : base;
  endfunction

  task automatic model_reset();
    {m_n, m_z, m_c, m_v} = 4'b0000;
    {m_valid, m_pc, m_reg, m_mem, m_undef} = 5'b0;
    m_exec = 0;
    m_squash = 0;
  endtask

  task automatic model_step();
    bit p;
    p = passes(cond_i);
    if (stall_i) return;
    if (flush_i) begin
      {m_valid, m_pc, m_reg, m_mem, m_undef} = 5'b0;
      return;
    end
    m_valid = valid_i;
    m_pc    = valid_i && pcs_i && p;
    m_reg   = valid_i && reg_w_i && !no_write_i && p;
    m_mem   = valid_i && mem_w_i && p;
    m_undef = valid_i && (cond_i == 4'hF);
    if (valid_i) begin
      if (p) begin
        if (flag_w_i[1]) begin m_n = alu_flags_i[3]; m_z = alu_flags_i[2]; end
        if (flag_w_i[0]) begin m_c = alu_flags_i[1]; m_v = alu_flags_i[0]; end
        if (m_exec < CNT_MAX) m_exec++;
      end else begin
        if (m_squash < CNT_MAX) m_squash++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(valid_o),     32'(m_valid));
    chk({tag, ".pc"},    32'(pc_src_o),    32'(m_pc));
    chk({tag, ".reg"},   32'(reg_write_o), 32'(m_reg));
    chk({tag, ".mem"},   32'(mem_write_o), 32'(m_mem));
    chk({tag, ".undef"}, 32'(undef_o),     32'(m_undef));
    chk({tag, ".flags"}, 32'(flags_o),     32'({m_n, m_z, m_c, m_v}));
`ifdef COND_PERF_CNT_EN
    chk({tag, ".exec"},   32'(exec_cnt_o),   32'(m_exec));
    chk({tag, ".squash"}, 32'(squash_cnt_o), 32'(m_squash));
`endif
  endtask

  // Inputs are driven at the falling edge; outputs are checked at the next one.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    valid_i = 0; stall_i = 0; flush_i = 0; cond_i = 4'hE; alu_flags_i = 0;
    flag_w_i = 0; pcs_i = 0; reg_w_i = 0; mem_w_i = 0; no_write_i = 0;
  endtask

  task automatic instr(input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu,
                       input bit pcs, input bit rw, input bit mw);
    valid_i = 1; stall_i = 0; flush_i = 0; cond_i = cond; flag_w_i = fw;
    alu_flags_i = alu; pcs_i = pcs; reg_w_i = rw; mem_w_i = mw; no_write_i = 0;
  endtask

  // Reset is asserted between edges and must clear outputs without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    chk({tag, ".now_valid"}, 32'(valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    compare_all("rst");
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) cycle("rst_idle");
    chk("rst_idle.flags_const", 32'(flags_o), 32'h0);

    // Flag write then dependent EQ/NE.
    instr(4'hE, 2'b11, 4'b0100, 0, 0, 0); cycle("fw_al");
    chk("fw_al.flags_const", 32'(flags_o), 32'b0100);
    instr(4'h0, 2'b00, 4'b0000, 0, 1, 0); cycle("fw_eq");
    chk("fw_eq.reg_const", 32'(reg_write_o), 32'd1);
    instr(4'h1, 2'b00, 4'b0000, 0, 1, 0); cycle("fw_ne");
    chk("fw_ne.reg_const", 32'(reg_write_o), 32'd0);
    chk("fw_ne.valid_const", 32'(valid_o), 32'd1);

    // Partial write: only C,V replaced.
    instr(4'hE, 2'b11, 4'b1010, 0, 0, 0); cycle("pw_set");
    instr(4'hE, 2'b01, 4'b0101, 0, 0, 0); cycle("pw");
    chk("pw.flags_const", 32'(flags_o), 32'b1001);

    // Squashed flag setter.
    instr(4'hE, 2'b11, 4'b0000, 0, 0, 0); cycle("sq_clr");
    instr(4'h0, 2'b11, 4'b1111, 1, 1, 1); cycle("sq");
    chk("sq.flags_const", 32'(flags_o), 32'h0);
    chk("sq.strobes_const", 32'({pc_src_o, reg_write_o, mem_write_o}), 32'h0);

    // Stall freezes everything, flush kills, stall beats flush.
    instr(4'hE, 2'b00, 4'b0000, 1, 1, 1); cycle("st_pre");
    instr(4'hE, 2'b11, 4'b1111, 0, 0, 0); stall_i = 1;
    for (int i = 0; i < 3; i++) cycle("stall");
    chk("stall.flags_const", 32'(flags_o), 32'h0);
    chk("stall.mem_const", 32'(mem_write_o), 32'd1);
    instr(4'hE, 2'b11, 4'b1111, 0, 0, 1); flush_i = 1; cycle("flush");
    chk("flush.mem_const", 32'(mem_write_o), 32'd0);
    chk("flush.flags_const", 32'(flags_o), 32'h0);
    instr(4'hE, 2'b00, 4'b0000, 0, 0, 0); cycle("sf_pre");
    stall_i = 1; flush_i = 1; cycle("stall_flush");
    chk("stall_flush.valid_const", 32'(valid_o), 32'd1);
    idle_inputs();

    // Async reset mid-stream.
    instr(4'hE, 2'b11, 4'b1111, 1, 1, 1); cycle("ar_pre");
    async_reset("ar");
    chk("ar.flags_const", 32'(flags_o), 32'h0);

`ifdef COND_PERF_CNT_EN
    for (int i = 0; i < 5; i++) begin
      instr(4'hE, 2'b00, 4'b0000, 0, 0, 0); cycle("cnt_al");
    end
    chk("cnt_al.exec_const", 32'(exec_cnt_o), 32'd3);
    instr(4'hF, 2'b00, 4'b0000, 0, 0, 0); cycle("cnt_nv");
    chk("cnt_nv.undef_const", 32'(undef_o), 32'd1);
    chk("cnt_nv.squash_const", 32'(squash_cnt_o), 32'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      valid_i     = ($urandom_range(0, 9) < 7);
      stall_i     = ($urandom_range(0, 9) < 2);
      flush_i     = ($urandom_range(0, 9) < 1);
      cond_i      = 4'($urandom_range(0, 15));
      alu_flags_i = 4'($urandom_range(0, 15));
      flag_w_i    = 2'($urandom_range(0, 3));
      pcs_i       = 1'($urandom_range(0, 1));
      reg_w_i     = 1'($urandom_range(0, 1));
      mem_w_i     = 1'($urandom_range(0, 1));
      no_write_i  = 1'($urandom_range(0, 1));
      cycle("rnd");
      if ($urandom_range(0, 99) == 0) async_reset("rnd_ar");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
